// File: rtl/cipher_pkg.sv
// Shared types and constants for the pixel XOR cipher stage.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   CH_W          width of one colour channel / one key byte
//   KEY_DROP_MAX  saturation value of the dropped-key counter
//   state_t       frame FSM states
//   rgb_t         one pixel or one key triple, {r, g, b}
//   rgb_xor       channel-wise XOR of a pixel with a key triple
package cipher_pkg;

  localparam int          CH_W         = 8;
  localparam logic [15:0] KEY_DROP_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Encryption and decryption are the same operation.
  function automatic rgb_t rgb_xor(input rgb_t pix, input rgb_t key);
    rgb_t res;
    res.r = pix.r ^ key.r;
    res.g = pix.g ^ key.g;
    res.b = pix.b ^ key.b;
    return res;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO holding keystream triples between generator and cipher.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push is refused when full unless a pop frees a slot in the same cycle.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   flush         synchronous empty; wins over push and pop
//   push, wdata   write request and data
//   pop           read request; head advances on the next edge
//   head          oldest entry (undefined while empty)
//   full, empty   occupancy flags
module key_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pixel_xor_cipher.sv
// XORs one buffered keystream triple into each RGB pixel of a frame.
// Latency: exactly 1 cycle from input accept to registered output.
// Backpressure: pix_in_ready drops when no key is buffered or the output register is stalled.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   key_r/g/b, key_ready           keystream triple and its capture strobe
//   start                          begins a frame (honoured in IDLE only)
//   pix_in_valid/ready, pix_in_*   plaintext pixel handshake
//   pix_out_valid/ready, pix_out_* ciphertext pixel handshake, pix_out_last on final pixel
//   busy                           high while a frame is in RUN or DRAIN
//   frame_done                     one-cycle pulse after the last output handshake
//   key_drop_cnt                   saturating count of keys lost to a full FIFO
module pixel_xor_cipher
  import cipher_pkg::*;
#(
  parameter int KEY_FIFO_DEPTH = 4,
  parameter int FRAME_PIXELS   = 65536,
  parameter int PIX_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] key_r,
  input  logic [PIX_W-1:0] key_g,
  input  logic [PIX_W-1:0] key_b,
  input  logic             key_ready,
  input  logic             start,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  input  logic [PIX_W-1:0] pix_in_r,
  input  logic [PIX_W-1:0] pix_in_g,
  input  logic [PIX_W-1:0] pix_in_b,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic [PIX_W-1:0] pix_out_r,
  output logic [PIX_W-1:0] pix_out_g,
  output logic [PIX_W-1:0] pix_out_b,
  output logic             pix_out_last,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      key_drop_cnt
);

  localparam int             CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   pix_cnt;
  rgb_t               out_q;
  logic               out_vld;
  logic               out_last;
  logic [15:0]        drop_cnt;

  logic [3*PIX_W-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;

  rgb_t               pix_in;
  rgb_t               key_head;
  logic               start_frame;
  logic               key_capture;
  logic               key_drop;
  logic               accept;
  logic               last_accept;
  logic               out_fire;

  assign pix_in   = {pix_in_r, pix_in_g, pix_in_b};
  assign key_head = fifo_head;

  // start is only meaningful in IDLE; it also flushes stale keys from the last frame.
  assign start_frame = (state == IDLE) && start;
  // Keys arriving outside a frame are ignored entirely, never counted as drops.
  assign key_capture = key_ready && ((state == RUN) || (state == DRAIN));
  assign accept      = pix_in_valid && pix_in_ready;
  assign last_accept = accept && (pix_cnt == LAST_IDX);
  assign out_fire    = out_vld && pix_out_ready;
  // When full, a same-cycle pop makes room, so only a full FIFO without a pop drops.
  assign key_drop    = key_capture && fifo_full && !accept;

  key_fifo #(
    .WIDTH (3*PIX_W),
    .DEPTH (KEY_FIFO_DEPTH)
  ) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_frame),
    .push  (key_capture),
    .wdata ({key_r, key_g, key_b}),
    .pop   (accept),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = RUN;
      RUN:     if (last_accept) state_nxt = DRAIN;
      // Only the last pixel can be in the output register once in DRAIN.
      DRAIN:   if (out_fire)    state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // pix_in_ready depends only on registered state and pix_out_ready, never on pix_in_valid.
  always_comb begin
    busy         = 1'b0;
    pix_in_ready = 1'b0;
    frame_done   = 1'b0;
    case (state)
      RUN: begin
        busy         = 1'b1;
        pix_in_ready = !fifo_empty && (!out_vld || pix_out_ready);
      end
      DRAIN:   busy       = 1'b1;
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- pixel counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (start_frame) begin
      pix_cnt <= '0;
    end else if (accept) begin
      pix_cnt <= (pix_cnt == LAST_IDX) ? '0 : pix_cnt + CNT_W'(1);
    end
  end

  // ---------------- output register ----------------
  // Holds steady while stalled; a handshake with no new accept just drops valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else if (accept) begin
      out_q    <= rgb_xor(pix_in, key_head);
      out_vld  <= 1'b1;
      out_last <= (pix_cnt == LAST_IDX);
    end else if (out_fire) begin
      out_vld  <= 1'b0;
    end
  end

  assign pix_out_valid = out_vld;
  assign pix_out_last  = out_last;
  assign pix_out_r     = out_q.r;
  assign pix_out_g     = out_q.g;
  assign pix_out_b     = out_q.b;

  // ---------------- dropped-key counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (start_frame) begin
      drop_cnt <= '0;
    end else if (key_drop && (drop_cnt != KEY_DROP_MAX)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign key_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_pixel_xor_cipher.sv
`timescale 1ns/1ps
module tb_pixel_xor_cipher;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] key_r = '0, key_g = '0, key_b = '0;
  logic       key_ready = 1'b0;
  logic       start = 1'b0;
  logic       pix_in_valid = 1'b0;
  logic       pix_in_ready;
  logic [7:0] pix_in_r = '0, pix_in_g = '0, pix_in_b = '0;
  logic       pix_out_valid;
  logic       pix_out_ready = 1'b0;
  logic [7:0] pix_out_r, pix_out_g, pix_out_b;
  logic       pix_out_last;
  logic       busy;
  logic       frame_done;
  logic [15:0] key_drop_cnt;

  int total = 0;
  int bad   = 0;

  // Expected output stream: {r, g, b, last}
  logic [24:0] exp_q[$];
  logic        prev_acc = 1'b0;

  always #5 clk = ~clk;

  pixel_xor_cipher #(
    .KEY_FIFO_DEPTH (4),
    .FRAME_PIXELS   (3),
    .PIX_W          (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_r         (key_r),
    .key_g         (key_g),
    .key_b         (key_b),
    .key_ready     (key_ready),
    .start         (start),
    .pix_in_valid  (pix_in_valid),
    .pix_in_ready  (pix_in_ready),
    .pix_in_r      (pix_in_r),
    .pix_in_g      (pix_in_g),
    .pix_in_b      (pix_in_b),
    .pix_out_valid (pix_out_valid),
    .pix_out_ready (pix_out_ready),
    .pix_out_r     (pix_out_r),
    .pix_out_g     (pix_out_g),
    .pix_out_b     (pix_out_b),
    .pix_out_last  (pix_out_last),
    .busy          (busy),
    .frame_done    (frame_done),
    .key_drop_cnt  (key_drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, so a valid&&ready seen here
  // is the handshake that completes on the next rising edge.
  always @(negedge clk) begin
    logic [24:0] e;
    if (rst) begin
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) check("latency_vld", pix_out_valid, 1);
      if (pix_out_valid && pix_out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h%h%h last=%b, expected no output",
                   pix_out_r, pix_out_g, pix_out_b, pix_out_last);
        end else begin
          e = exp_q.pop_front();
          check("out_pixel", {pix_out_r, pix_out_g, pix_out_b, pix_out_last}, e);
        end
      end
      prev_acc = pix_in_valid && pix_in_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    key_r = r; key_g = g; key_b = b;
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] pix, input logic [23:0] expd, input logic last);
    int n;
    {pix_in_r, pix_in_g, pix_in_b} = pix;
    pix_in_valid = 1'b1;
    exp_q.push_back({expd, last});
    n = 0;
    @(negedge clk);
    while (!pix_in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (!pix_in_ready) begin
      bad++;
      $display("FAIL accept_timeout: pix_in_ready=%b after %0d cycles, expected 1", pix_in_ready, n);
    end
    tick();
    pix_in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {pix_out_valid, pix_out_last, pix_in_ready, busy, frame_done}, 0);
    check({tag, "_dat"}, {pix_out_r, pix_out_g, pix_out_b}, 0);
    check({tag, "_drop"}, key_drop_cnt, 0);
  endtask

  logic [23:0] hold_keys [2];

  initial begin
    int n;
    // ---------------- reset ----------------
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_init");
    tick();
    rst = 1'b0;
    tick();

    // ---------------- key_ready in IDLE is ignored ----------------
    for (int i = 0; i < 6; i++) push_key(8'(i), 8'(i), 8'(i));
    @(negedge clk);
    check("idle_drop", key_drop_cnt, 0);
    check("idle_rdy", pix_in_ready, 0);
    check("idle_busy", busy, 0);
    tick();

    // ---------------- frame 1: basic XOR, starvation, backpressure ----------------
    pulse_start();
    pix_out_ready = 1'b1;
    {pix_in_r, pix_in_g, pix_in_b} = 24'hA55AFF;
    pix_in_valid = 1'b1;
    exp_q.push_back({24'hB478CC, 1'b0});
    repeat (3) begin
      @(negedge clk);
      check("starve_rdy", pix_in_ready, 0);
      check("run_busy", busy, 1);
      tick();
    end
    push_key(8'h11, 8'h22, 8'h33);
    pix_out_ready = 1'b0;
    @(negedge clk);
    check("key_then_rdy", pix_in_ready, 1);
    tick();  // pixel 1 accepted
    {pix_in_r, pix_in_g, pix_in_b} = 24'h000000;
    exp_q.push_back({24'h445566, 1'b0});
    hold_keys[0] = 24'h445566;
    hold_keys[1] = 24'h778899;
    for (int i = 0; i < 5; i++) begin
      key_ready = (i < 2);
      if (i < 2) {key_r, key_g, key_b} = hold_keys[i];
      @(negedge clk);
      check("hold_vld", pix_out_valid, 1);
      check("hold_dat", {pix_out_r, pix_out_g, pix_out_b}, 24'hB478CC);
      check("hold_rdy", pix_in_ready, 0);
      tick();
    end
    key_ready = 1'b0;
    pix_out_ready = 1'b1;
    @(negedge clk);
    check("release_rdy", pix_in_ready, 1);
    tick();  // pixel 1 out handshake, pixel 2 accepted on the same edge
    {pix_in_r, pix_in_g, pix_in_b} = 24'hFFFFFF;
    exp_q.push_back({24'h887766, 1'b1});
    @(negedge clk);
    check("p3_rdy", pix_in_ready, 1);
    tick();  // pixel 3 accepted
    pix_in_valid = 1'b0;
    @(negedge clk);
    check("f1_drain_busy", busy, 1);
    check("f1_drain_done", frame_done, 0);
    check("f1_last", pix_out_last, 1);
    @(negedge clk);
    check("f1_done_pulse", frame_done, 1);
    check("f1_done_busy", busy, 0);
    @(negedge clk);
    check("f1_done_end", frame_done, 0);
    tick();

    // ---------------- frame 2: overflow, push+pop when full, start ignored ----------------
    pulse_start();
    push_key(8'h01, 8'h02, 8'h03);
    push_key(8'h10, 8'h20, 8'h30);
    push_key(8'hC3, 8'h3C, 8'h5A);
    push_key(8'hAA, 8'hBB, 8'hCC);
    @(negedge clk);
    check("full_nodrop", key_drop_cnt, 0);
    tick();
    push_key(8'hDE, 8'hAD, 8'hBE);
    push_key(8'hEF, 8'hBE, 8'hEF);
    @(negedge clk);
    check("ovf_drop", key_drop_cnt, 2);
    tick();
    // Accept while full with a key arriving on the same edge: no drop.
    {pix_in_r, pix_in_g, pix_in_b} = 24'hF00FFF;
    pix_in_valid = 1'b1;
    exp_q.push_back({24'hF10DFC, 1'b0});
    {key_r, key_g, key_b} = 24'h999999;
    key_ready = 1'b1;
    @(negedge clk);
    check("pushpop_rdy", pix_in_ready, 1);
    tick();
    key_ready = 1'b0;
    pix_in_valid = 1'b0;
    @(negedge clk);
    check("pushpop_drop", key_drop_cnt, 2);
    tick();
    pulse_start();  // ignored in RUN
    send_pixel(24'h123456, 24'h021466, 1'b0);
    send_pixel(24'h3CC3A5, 24'hFFFFFF, 1'b1);
    // DRAIN with keys still buffered: input must stay blocked.
    {pix_in_r, pix_in_g, pix_in_b} = 24'h777777;
    pix_in_valid = 1'b1;
    @(negedge clk);
    check("drain_rdy", pix_in_ready, 0);
    check("drain_busy", busy, 1);
    tick();
    pix_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("f2_done", frame_done, 1);
    tick();

    // ---------------- frame 3: reset mid-RUN ----------------
    pulse_start();
    push_key(8'h01, 8'h01, 8'h01);
    push_key(8'h02, 8'h02, 8'h02);
    pix_out_ready = 1'b0;
    {pix_in_r, pix_in_g, pix_in_b} = 24'h101010;
    pix_in_valid = 1'b1;
    @(negedge clk);
    check("f3_rdy", pix_in_ready, 1);
    tick();  // pixel 1 accepted; its output stays stalled
    {pix_in_r, pix_in_g, pix_in_b} = 24'h202020;
    @(negedge clk);
    check("f3_pend_vld", pix_out_valid, 1);
    check("f3_pend_dat", {pix_out_r, pix_out_g, pix_out_b}, 24'h111111);
    tick();
    rst = 1'b1;
    {key_r, key_g, key_b} = 24'h5A5A5A;
    key_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    tick();
    rst = 1'b0;
    pix_out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", pix_in_ready, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_drop", key_drop_cnt, 0);
    tick();
    key_ready = 1'b0;
    pix_in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_nodone", frame_done, 0);
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: %0d outputs outstanding, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pixel_xor_cipher.md
Name: pixel_xor_cipher

Overview:
- Stream-cipher stage directly downstream of the chaotic-LFSR keystream generator.
- Captures each {R,G,B} key byte triple when the generator pulses its key-ready strobe, and buffers the triples in a small FIFO.
- XORs one key triple into each incoming RGB pixel under valid/ready handshakes.
- Counts pixels per frame, flags the last pixel, and reports frame completion and any dropped keys.

Parameters:
- KEY_FIFO_DEPTH, 4, number of key triples buffered; power of two, at least 2.
- FRAME_PIXELS, 65536, pixels per frame; at least 1.
- PIX_W, 8, bits per colour channel; must equal the key byte width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- key_r / key_g / key_b  in  PIX_W each  keystream bytes from the generator; valid only while key_ready=1.
- key_ready  in  1  single-cycle strobe from the generator, one every 8 clocks.
- start  in  1  pulse that begins a frame.
- pix_in_valid  in  1  input pixel valid.
- pix_in_ready  out  1  input pixel accepted when valid and ready are both 1.
- pix_in_r / pix_in_g / pix_in_b  in  PIX_W each  plaintext pixel.
- pix_out_valid  out  1  ciphertext valid.
- pix_out_ready  in  1  downstream ready.
- pix_out_r / pix_out_g / pix_out_b  out  PIX_W each  ciphertext pixel.
- pix_out_last  out  1  qualifies the final pixel of the frame.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse when a frame completes.
- key_drop_cnt  out  16  saturating count of key triples discarded because the FIFO was full.

Behaviour:
- Reset (asynchronous):
  - State = IDLE; FIFO emptied; pixel counter = 0.
  - All outputs 0, including pix_out_* data, pix_out_valid, pix_out_last, pix_in_ready, busy, frame_done and key_drop_cnt.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → RUN next cycle.
  - On the same edge: flush the FIFO, clear the pixel counter, clear key_drop_cnt.
  - key_ready pulses in IDLE are ignored and not counted as drops.
- Key capture (RUN and DRAIN only):
  - On key_ready=1, push {key_r, key_g, key_b} if the FIFO is not full.
  - If the FIFO is full, discard the triple and increment key_drop_cnt, saturating at 16'hFFFF.
  - A push and a pop in the same cycle while full: the pop frees the slot and the push succeeds, with no drop.
- RUN, input side:
  - pix_in_ready = FIFO not empty AND (pix_out_valid=0 OR pix_out_ready=1).
  - pix_in_ready is combinational from registered state and pix_out_ready only.
- RUN, on accept:
  - Pop the FIFO head.
  - Next cycle: pix_out_x = pix_in_x XOR key_x per channel, pix_out_valid=1.
  - pix_out_last = 1 when the accepted pixel index equals FRAME_PIXELS-1.
  - Latency is exactly 1 cycle.
  - The counter increments by 1 per accept and wraps to 0 after the last pixel.
- RUN → DRAIN when the pixel with index FRAME_PIXELS-1 is accepted. In DRAIN, pix_in_ready=0.
- Output hold:
  - While pix_out_valid=1 and pix_out_ready=0, all pix_out_* signals are held stable.
  - A handshake with no new accept clears pix_out_valid next cycle.
- DRAIN → DONE on the handshake of the last output pixel.
- DONE:
  - frame_done=1 for exactly one cycle, then IDLE.
  - Remaining FIFO keys are retained until the next start flushes them.
- Other rules:
  - start outside IDLE is ignored.
  - The keystream is consumed strictly in FIFO order: one key triple per pixel, never reused.
  - Decryption is the identical operation, provided both sides see the same key drop pattern.
  - A reset mid-frame aborts the frame; no frame_done is generated.

Decomposition:
- Shared package cipher_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - rgb_t packed struct {r, g, b} of PIX_W bits each;
  - constant KEY_DROP_MAX = 16'hFFFF.
- Sub-module key_fifo:
  - synchronous FIFO, width 3*PIX_W, depth KEY_FIFO_DEPTH;
  - signals: push, pop, full, empty, head data;
  - same clk and asynchronous rst.
- FSM, counter and output register live in pixel_xor_cipher.

Test Plan:
- Reset values: assert rst mid-RUN with pixel 2 pending → next cycle all outputs 0, busy=0, no frame_done, and pix_in_ready=0 even with keys presented.
- Basic XOR, FRAME_PIXELS=3:
  - start, then key triples (11,22,33), (44,55,66), (77,88,99);
  - pixels (A5,5A,FF), (00,00,00), (FF,FF,FF);
  - → outputs (B4,78,CC), (44,55,66), (88,77,66), each 1 cycle after accept;
  - last=1 on the third; frame_done pulses one cycle after the third output handshake.
- Key starvation: start, then pix_in_valid=1 with no key_ready → pix_in_ready=0 until the first key pushed, then accept on the following cycle.
- Backpressure: pix_out_ready=0 for 5 cycles with valid output (B4,78,CC) → data and valid stable, pix_in_ready=0; release → handshake, and next pixel accepted same cycle.
- FIFO overflow, depth 4: 6 key_ready pulses with no pixels → key_drop_cnt=2; subsequent pixels use keys 1–4 in order.
- Ignored events: key_ready in IDLE → FIFO stays empty and key_drop_cnt=0; start during RUN → counter and FIFO unchanged.
